// File: rtl/tdm_demux_pkg.sv
// Shared types and constants for the TDM demultiplexer slice.
// Optional sync checking is enabled by defining TDM_DEMUX_SYNC_CHECK_EN.
package tdm_demux_pkg;

  localparam int DEFAULT_NUM_CHANNELS = 4;
  localparam int DEFAULT_DATA_WIDTH   = 8;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } DemuxState;

  // Slot counter width; a single-slot frame would still need one bit.
  function automatic int countWidth(input int numSlots);
    return (numSlots > 1) ? $clog2(numSlots) : 1;
  endfunction

endpackage

// File: rtl/tdm_demux_slot_counter.sv
// Slot counter for the TDM demultiplexer: load-to-zero on sync, wrapping
// increment on accept, hold otherwise.
module tdm_slot_counter #(
  parameter int NUM_SLOTS = 4,
  parameter int CW        = 2
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_load,
  input  logic          i_inc,
  output logic [CW-1:0] o_count
);

  localparam logic [CW-1:0] LAST_SLOT = CW'(NUM_SLOTS - 1);

  logic [CW-1:0] r_count;
  logic [CW-1:0] w_base;
  logic [CW-1:0] w_next;

  // Load and increment together means "this sample was slot 0, next is slot 1".
  always_comb begin
    w_base = i_load ? '0 : r_count;
    w_next = w_base;
    if (i_inc) begin
      w_next = (w_base == LAST_SLOT) ? '0 : w_base + CW'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else begin
      r_count <= w_next;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/tdm_demux.sv
// Time-division demultiplexer with frame-sync lock and per-channel strobes.
// Define TDM_DEMUX_SYNC_CHECK_EN to enable sync-error reporting and HUNT re-entry.
module tdm_demux
  import tdm_demux_pkg::*;
#(
  parameter int NUM_CHANNELS = DEFAULT_NUM_CHANNELS,
  parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH
) (
  input  logic                               Clock_In,
  input  logic                               Reset_N_In,
  input  logic                               Enable_In,
  input  logic                               Data_Valid_In,
  input  logic                               Frame_Sync_In,
  input  logic [DATA_WIDTH-1:0]              Data_In,
  output logic [NUM_CHANNELS*DATA_WIDTH-1:0] Channel_Data_Out,
  output logic [NUM_CHANNELS-1:0]            Channel_Valid_Out,
  output logic                               Frame_Done_Out,
  output logic                               Sync_Error_Out,
  output logic                               Locked_Out
);

  localparam int CW = countWidth(NUM_CHANNELS);
  localparam logic [CW-1:0] LAST_SLOT = CW'(NUM_CHANNELS - 1);

  DemuxState r_state;
  DemuxState w_stateNext;

  logic                               w_accept;
  logic                               w_write;
  logic                               w_load;
  logic                               w_inc;
  logic                               w_syncErr;
  logic [CW-1:0]                      w_count;
  logic [CW-1:0]                      w_slot;
  logic [DATA_WIDTH-1:0]              r_chan [NUM_CHANNELS];
  logic [NUM_CHANNELS*DATA_WIDTH-1:0] w_chanFlat;
  logic [NUM_CHANNELS-1:0]            r_chanValid;
  logic                               r_frameDone;
  logic                               r_syncErr;

  assign w_accept = Enable_In && Data_Valid_In;

  tdm_slot_counter #(
    .NUM_SLOTS (NUM_CHANNELS),
    .CW        (CW)
  ) u_slotCounter (
    .i_clk   (Clock_In),
    .i_rst_n (Reset_N_In),
    .i_load  (w_load),
    .i_inc   (w_inc),
    .o_count (w_count)
  );

  always_ff @(posedge Clock_In or negedge Reset_N_In) begin
    if (!Reset_N_In) begin
      r_state <= HUNT;
    end else begin
      r_state <= w_stateNext;
    end
  end

  always_comb begin
    w_stateNext = r_state;
    unique case (r_state)
      HUNT: begin
        if (w_accept && Frame_Sync_In) begin
          w_stateNext = LOCKED;
        end
      end
      LOCKED: begin
`ifdef TDM_DEMUX_SYNC_CHECK_EN
        if (w_accept && !Frame_Sync_In && (w_count == '0)) begin
          w_stateNext = HUNT;
        end
`endif
      end
      default: w_stateNext = HUNT;
    endcase
  end

  // A sync always means "this is slot 0", even mid-frame; only the error report is optional.
  always_comb begin
    w_write   = 1'b0;
    w_slot    = w_count;
    w_load    = 1'b0;
    w_inc     = 1'b0;
    w_syncErr = 1'b0;
    if (w_accept) begin
      unique case (r_state)
        HUNT: begin
          if (Frame_Sync_In) begin
            w_write = 1'b1;
            w_slot  = '0;
            w_load  = 1'b1;
            w_inc   = 1'b1;
          end
        end
        LOCKED: begin
          if (Frame_Sync_In) begin
            w_write = 1'b1;
            w_slot  = '0;
            w_load  = 1'b1;
            w_inc   = 1'b1;
`ifdef TDM_DEMUX_SYNC_CHECK_EN
            w_syncErr = (w_count != '0);
`endif
          end
`ifdef TDM_DEMUX_SYNC_CHECK_EN
          else if (w_count == '0) begin
            w_syncErr = 1'b1;
            w_load    = 1'b1;
          end
`endif
          else begin
            w_write = 1'b1;
            w_inc   = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge Clock_In or negedge Reset_N_In) begin
    if (!Reset_N_In) begin
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        r_chan[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        if (w_write && (w_slot == CW'(i))) begin
          r_chan[i] <= Data_In;
        end
      end
    end
  end

  always_ff @(posedge Clock_In or negedge Reset_N_In) begin
    if (!Reset_N_In) begin
      r_chanValid <= '0;
      r_frameDone <= 1'b0;
      r_syncErr   <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        r_chanValid[i] <= w_write && (w_slot == CW'(i));
      end
      r_frameDone <= w_write && (w_slot == LAST_SLOT);
      r_syncErr   <= w_syncErr;
    end
  end

  for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_pack
    assign w_chanFlat[g*DATA_WIDTH +: DATA_WIDTH] = r_chan[g];
  end

  // Strobes are gated so a stalled block never shows a pulse, even one registered before the stall.
  assign Channel_Data_Out  = Enable_In ? w_chanFlat : 'z;
  assign Channel_Valid_Out = Enable_In ? r_chanValid : '0;
  assign Frame_Done_Out    = Enable_In && r_frameDone;
  assign Sync_Error_Out    = Enable_In && r_syncErr;
  assign Locked_Out        = (r_state == LOCKED);

endmodule

// File: tb/tb_tdm_demux.sv
// Self-checking bench for tdm_demux (NUM_CHANNELS=4, DATA_WIDTH=8).
// Expectations follow TDM_DEMUX_SYNC_CHECK_EN when it is defined for the build.
module tb_tdm_demux;

  localparam int N  = 4;
  localparam int DW = 8;

`ifdef TDM_DEMUX_SYNC_CHECK_EN
  localparam bit SYNC_CHK = 1'b1;
`else
  localparam bit SYNC_CHK = 1'b0;
`endif

  typedef struct {
    logic          en;
    logic          dv;
    logic          fs;
    logic [DW-1:0] data;
    logic [N-1:0]  v;
    logic          d;
    logic          e;
    logic          l;
  } VecT;

  typedef struct {
    logic [N*DW-1:0] data;
    logic [N-1:0]    v;
    logic            d;
    logic            e;
    logic            l;
  } ExpT;

  logic            clk = 1'b0;
  logic            rstN;
  logic            en;
  logic            dv;
  logic            fs;
  logic [DW-1:0]   din;
  logic [N*DW-1:0] chData;
  logic [N-1:0]    chValid;
  logic            done;
  logic            serr;
  logic            locked;

  int errors = 0;
  int checks = 0;

  VecT           tbl[$];
  ExpT           sbQ[$];
  logic [DW-1:0] mdl [N];

  tdm_demux #(
    .NUM_CHANNELS (N),
    .DATA_WIDTH   (DW)
  ) dut (
    .Clock_In          (clk),
    .Reset_N_In        (rstN),
    .Enable_In         (en),
    .Data_Valid_In     (dv),
    .Frame_Sync_In     (fs),
    .Data_In           (din),
    .Channel_Data_Out  (chData),
    .Channel_Valid_Out (chValid),
    .Frame_Done_Out    (done),
    .Sync_Error_Out    (serr),
    .Locked_Out        (locked)
  );

  always #5 clk = ~clk;

  function automatic logic [N*DW-1:0] mdlVec();
    logic [N*DW-1:0] r;
    for (int i = 0; i < N; i++) r[i*DW +: DW] = mdl[i];
    return r;
  endfunction

  task automatic resetModel();
    for (int i = 0; i < N; i++) mdl[i] = '0;
  endtask

  task automatic check1(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    ExpT e;
    if (sbQ.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s: scoreboard empty", tag);
      return;
    end
    e = sbQ.pop_front();
    check1({tag, ".valid"},  32'(chValid), 32'(e.v));
    check1({tag, ".done"},   32'(done),    32'(e.d));
    check1({tag, ".err"},    32'(serr),    32'(e.e));
    check1({tag, ".locked"}, 32'(locked),  32'(e.l));
    check1({tag, ".data"},   chData,       e.data);
  endtask

  // Drives one cycle, predicts its output cycle, and compares after the edge.
  task automatic applyStimulus(input VecT v, input string tag);
    ExpT e;
    en  = v.en;
    dv  = v.dv;
    fs  = v.fs;
    din = v.data;
    for (int i = 0; i < N; i++) if (v.v[i]) mdl[i] = v.data;
    e.data = v.en ? mdlVec() : {(N*DW){1'bz}};
    e.v = v.v;
    e.d = v.d;
    e.e = v.e;
    e.l = v.l;
    sbQ.push_back(e);
    @(posedge clk);
    #1;
    checkOutput(tag);
  endtask

  task automatic checkQuiet(input string tag);
    check1({tag, ".valid"},  32'(chValid), 32'd0);
    check1({tag, ".done"},   32'(done),    32'd0);
    check1({tag, ".err"},    32'(serr),    32'd0);
    check1({tag, ".locked"}, 32'(locked),  32'd0);
    check1({tag, ".data"},   chData,       32'd0);
  endtask

  function automatic VecT mk(input logic e_, input logic dv_, input logic fs_, input logic [7:0] d_,
                             input logic [3:0] v_, input logic dn_, input logic er_, input logic l_);
    VecT r;
    r.en = e_; r.dv = dv_; r.fs = fs_; r.data = d_;
    r.v = v_; r.d = dn_; r.e = er_; r.l = l_;
    return r;
  endfunction

  initial begin
    rstN = 1'b0;
    en   = 1'b1;
    dv   = 1'b0;
    fs   = 1'b0;
    din  = '0;
    resetModel();

    // Two clean frames, an idle gap, mid-frame resync, missing sync, stall.
    tbl.push_back(mk(1, 1, 1, 8'h10, 4'b0001, 0, 0, 1));
    tbl.push_back(mk(1, 1, 0, 8'h11, 4'b0010, 0, 0, 1));
    tbl.push_back(mk(1, 1, 0, 8'h12, 4'b0100, 0, 0, 1));
    tbl.push_back(mk(1, 1, 0, 8'h13, 4'b1000, 1, 0, 1));
    tbl.push_back(mk(1, 1, 1, 8'h20, 4'b0001, 0, 0, 1));
    tbl.push_back(mk(1, 1, 0, 8'h21, 4'b0010, 0, 0, 1));
    tbl.push_back(mk(1, 1, 0, 8'h22, 4'b0100, 0, 0, 1));
    tbl.push_back(mk(1, 1, 0, 8'h23, 4'b1000, 1, 0, 1));
    tbl.push_back(mk(1, 0, 0, 8'hEE, 4'b0000, 0, 0, 1));
    tbl.push_back(mk(1, 0, 1, 8'hEF, 4'b0000, 0, 0, 1));
    tbl.push_back(mk(1, 1, 1, 8'h30, 4'b0001, 0, 0, 1));
    tbl.push_back(mk(1, 1, 0, 8'h31, 4'b0010, 0, 0, 1));
    tbl.push_back(mk(1, 1, 1, 8'h55, 4'b0001, 0, SYNC_CHK, 1));
    tbl.push_back(mk(1, 1, 0, 8'h56, 4'b0010, 0, 0, 1));
    tbl.push_back(mk(1, 1, 0, 8'h57, 4'b0100, 0, 0, 1));
    tbl.push_back(mk(1, 1, 0, 8'h58, 4'b1000, 1, 0, 1));
    tbl.push_back(mk(1, 1, 0, 8'h66, SYNC_CHK ? 4'b0000 : 4'b0001, 0, SYNC_CHK, !SYNC_CHK));
    tbl.push_back(mk(1, 1, 0, 8'h77, SYNC_CHK ? 4'b0000 : 4'b0010, 0, 0, !SYNC_CHK));
    tbl.push_back(mk(1, 1, 1, 8'h40, 4'b0001, 0, 0, 1));
    tbl.push_back(mk(1, 1, 0, 8'h41, 4'b0010, 0, 0, 1));
    tbl.push_back(mk(0, 1, 0, 8'h99, 4'b0000, 0, 0, 1));
    tbl.push_back(mk(0, 1, 1, 8'h9A, 4'b0000, 0, 0, 1));
    tbl.push_back(mk(0, 1, 0, 8'h9B, 4'b0000, 0, 0, 1));
    tbl.push_back(mk(1, 1, 0, 8'h42, 4'b0100, 0, 0, 1));
    tbl.push_back(mk(1, 1, 0, 8'h43, 4'b1000, 1, 0, 1));

    repeat (2) @(posedge clk);
    #1;
    checkQuiet("reset");
    rstN = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < tbl.size(); i++) begin
      applyStimulus(tbl[i], $sformatf("vec%0d", i));
    end

    // Asynchronous reset landing between slot 1 and slot 2.
    applyStimulus(mk(1, 1, 1, 8'h50, 4'b0001, 0, 0, 1), "rstSeq.s0");
    applyStimulus(mk(1, 1, 0, 8'h51, 4'b0010, 0, 0, 1), "rstSeq.s1");
    dv = 1'b0;
    #1;
    rstN = 1'b0;
    #1;
    resetModel();
    checkQuiet("rstSeq.async");
    #1;
    rstN = 1'b1;
    @(posedge clk);
    #1;
    checkQuiet("rstSeq.after");
    applyStimulus(mk(1, 1, 0, 8'h52, 4'b0000, 0, 0, 0), "rstSeq.s2drop");

    // Samples before the first sync are dropped.
    applyStimulus(mk(1, 1, 0, 8'hAA, 4'b0000, 0, 0, 0), "hunt.aa");
    applyStimulus(mk(1, 1, 0, 8'hBB, 4'b0000, 0, 0, 0), "hunt.bb");
    applyStimulus(mk(1, 1, 1, 8'h01, 4'b0001, 0, 0, 1), "hunt.sync");
    applyStimulus(mk(1, 0, 0, 8'h00, 4'b0000, 0, 0, 1), "hunt.idle");

    check1("sb.empty", 32'(sbQ.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tdm_demux.md
# tdm_demux

Time-division demultiplexer: the receive-side counterpart of the team's multiplexers. It takes a single serial stream of samples in which channel slots are interleaved in a fixed order, with a frame-sync marker on slot 0. Each sample is routed into a per-channel holding register, and a per-channel valid strobe is raised when that register is written. It sits at the far end of a link driven by a select-counter-driven N:1 MUX and reconstructs the N parallel channels, with sync-loss detection and re-acquisition.

## Interface
Parameters:
- NUM_CHANNELS, 4, number of interleaved slots per frame (≥2)
- DATA_WIDTH, 8, width of each sample

Ports (one clock; reset is asynchronous and active-low):
- Clock_In  input  1  rising-edge clock
- Reset_N_In  input  1  asynchronous active-low reset
- Enable_In  input  1  block enable; low = stall and float data outputs
- Data_Valid_In  input  1  Data_In/Frame_Sync_In carry a sample this cycle
- Frame_Sync_In  input  1  marks current sample as slot 0; qualified by Data_Valid_In
- Data_In  input  DATA_WIDTH  multiplexed sample
- Channel_Data_Out  output  NUM_CHANNELS*DATA_WIDTH  channel i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- Channel_Valid_Out  output  NUM_CHANNELS  one-cycle pulse per channel written
- Frame_Done_Out  output  1  one-cycle pulse when slot NUM_CHANNELS-1 is written
- Sync_Error_Out  output  1  one-cycle pulse on sync violation
- Locked_Out  output  1  high while in state LOCKED

## Operation
- A sample is accepted on a rising edge when Enable_In && Data_Valid_In; all other cycles are idle.
- Slot counter is $clog2(NUM_CHANNELS) bits wide and wraps from NUM_CHANNELS-1 to 0.
- States:
  - HUNT: discard samples without sync. An accepted sample with sync writes channel 0, sets counter to 1 (0 if NUM_CHANNELS wraps), and moves to LOCKED.
  - LOCKED: an accepted sample writes channel[counter] and increments the counter.
- Sync violations in LOCKED:
  - Sync on a sample with counter≠0: pulse Sync_Error_Out, write the sample as channel 0, set counter to 1, stay LOCKED (resync).
  - No sync on a sample with counter==0: pulse Sync_Error_Out, discard the sample, go to HUNT.
- Channel registers hold their value until overwritten; there is no clearing between frames.
- Enable_In low:
  - Channel_Data_Out is driven 'Z'.
  - Internal registers, state and counter are held.
  - All pulse outputs are 0.
- Reset (asynchronous, any time, including mid-frame):
  - State HUNT, counter 0, all channel registers 0.
  - Channel_Valid_Out, Frame_Done_Out, Sync_Error_Out and Locked_Out are all 0.

## Timing
- Latency of 1 cycle: the sample accepted at edge k appears on Channel_Data_Out, with its Channel_Valid_Out bit high, during the cycle following edge k.
- At most one Channel_Valid_Out bit is high in any cycle.
- Frame_Done_Out is coincident with Channel_Valid_Out[NUM_CHANNELS-1].
- Sync_Error_Out is coincident with the output cycle of the offending sample.
- Locked_Out is registered from the state.
- Back-to-back valid samples are supported at full rate. Gaps of any length in Data_Valid_In are allowed and do not advance the counter.

## Configuration
- TDM_DEMUX_SYNC_CHECK_EN defined: sync checking and the HUNT re-entry behave as described above.
- TDM_DEMUX_SYNC_CHECK_EN undefined:
  - Sync_Error_Out is tied 0.
  - A missing sync at counter==0 is ignored: the sample is written to channel 0 and the block stays LOCKED.
  - A mid-frame sync still forces counter to slot 0 (silent resync).
  - HUNT is left only via the first sync after reset.

## Structure
- Package tdm_demux_pkg holds:
  - the state enum (HUNT, LOCKED);
  - a helper function for the counter width;
  - default parameter constants.
- Sub-module tdm_slot_counter is natural: it handles load-to-zero on sync, increment-with-wrap on accept, and hold otherwise, with the same clock and reset.
- Channel registers and the output tri-state live in the top.

## Test plan
(NUM_CHANNELS=4, DATA_WIDTH=8)
- Reset, then 2 frames of back-to-back samples 0x10..0x13 / 0x20..0x23 with sync on 0x10 and 0x20 -> Channel_Valid_Out pulses 0001,0010,0100,1000 per frame; Frame_Done_Out on the 4th and 8th outputs; final channel data {0x23,0x22,0x21,0x20}; Locked_Out high after the first sample.
- Samples before the first sync (0xAA, 0xBB), then sync 0x01 -> the first two samples are discarded; channel 0 = 0x01.
- Sync asserted on the third sample of a frame (0x55) -> Sync_Error_Out pulse; channel 0 = 0x55; the next sample goes to channel 1.
- Frame ends, then the next sample 0x66 arrives without sync -> Sync_Error_Out pulse; Locked_Out drops; 0x66 is discarded (macro defined). With the macro undefined: no error and channel 0 = 0x66.
- Enable_In low for 3 cycles mid-frame with Data_Valid_In high -> Channel_Data_Out = 'Z'; no pulses; after re-enable the counter resumes at the held slot.
- Reset_N_In pulsed low between slot 1 and slot 2 -> all outputs 0 immediately; HUNT; the next non-sync sample is discarded.
